// File: rtl/lcd_field_sequencer.sv
// Glyph sequencer for one LCD readout line: label, colon, sign, integer digits,
// dot and fraction digits, each sent as ROM address / x-origin / width over valid/ready.
module lcd_field_sequencer #(
  parameter int CHANNELS     = 2,
  parameter int DIGITS       = 3,
  parameter int FRAC         = 1,
  parameter int ADDR_W       = 9,
  parameter int X_W          = 16,
  parameter int GLYPH_STRIDE = 32,
  parameter int LABEL_BASE   = 320,
  parameter int COLON_ADDR   = 430,
  parameter int DOT_ADDR     = 418,
  parameter int MINUS_ADDR   = 448,
  parameter int BLANK_ADDR   = 480,
  parameter int X_ORIGIN     = 20,
  parameter int WIDE_ADV     = 40,
  parameter int NARROW_ADV   = 30,
  parameter int WIDE_XS      = 31,
  parameter int NARROW_XS    = 12,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CHW         = (DIGITS + FRAC) * 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CW-1:0]            chan,
  input  logic                     lz_blank,
  input  logic [CHANNELS*CHW-1:0]  bcd_data,
  input  logic [CHANNELS-1:0]      neg,
  input  logic                     glyph_ready,
  output logic                     glyph_valid,
  output logic [ADDR_W-1:0]        addr_start,
  output logic [X_W-1:0]           window_x0,
  output logic [5:0]               x_size,
  output logic                     last,
  output logic                     busy,
  output logic                     done
);

  localparam int SLOTS = 4 + DIGITS + FRAC;
  localparam int SW    = $clog2(SLOTS);
  localparam int DOT_SLOT = 3 + DIGITS;

  typedef enum logic {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [SW-1:0]      slot_r;
  logic [CHW-1:0]     bcd_r;
  logic               neg_r;
  logic [CW-1:0]      chan_r;
  logic               lz_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [X_W-1:0]     x0_r;
  logic [5:0]         xs_r;
  logic               last_r;
  logic               done_r;

  logic [CW-1:0]      chan_sel_s;
  logic [CHW-1:0]     bcd_sel_s;
  logic               neg_sel_s;
  logic               accept_s;
  logic               final_s;
  logic [SW-1:0]      next_slot_s;

  function automatic logic [ADDR_W-1:0] digit_addr(input logic [3:0] nib);
    if (nib > 4'd9) return ADDR_W'(BLANK_ADDR);
    else            return ADDR_W'(32'(nib) * GLYPH_STRIDE);
  endfunction

  function automatic logic is_narrow(input logic [SW-1:0] s);
    return (s == SW'(1)) || (s == SW'(DOT_SLOT));
  endfunction

  // Leading-zero state runs across the integer digits MS first; the LS digit is never blanked.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [SW-1:0] s, input logic [CHW-1:0] b,
                                                  input logic n, input logic [CW-1:0] c, input logic lz);
    logic [ADDR_W-1:0] a;
    logic [3:0]        nib;
    logic              lead;
    a    = ADDR_W'(BLANK_ADDR);
    lead = lz;
    if (s == SW'(0)) begin
      a = ADDR_W'(LABEL_BASE + 32'(c) * GLYPH_STRIDE);
    end else if (s == SW'(1)) begin
      a = ADDR_W'(COLON_ADDR);
    end else if (s == SW'(2)) begin
      a = n ? ADDR_W'(MINUS_ADDR) : ADDR_W'(BLANK_ADDR);
    end else if (s == SW'(DOT_SLOT)) begin
      a = ADDR_W'(DOT_ADDR);
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        nib  = b[(DIGITS + FRAC - 1 - i) * 4 +: 4];
        lead = lead & (nib == 4'd0);
        if (s == SW'(3 + i)) begin
          a = (lead && (i != DIGITS - 1)) ? ADDR_W'(BLANK_ADDR) : digit_addr(nib);
        end
      end
      for (int j = 0; j < FRAC; j++) begin
        if (s == SW'(4 + DIGITS + j)) begin
          a = digit_addr(b[(FRAC - 1 - j) * 4 +: 4]);
        end
      end
    end
    return a;
  endfunction

  assign chan_sel_s  = (32'(chan) >= CHANNELS) ? {CW{1'b0}} : chan;
  assign bcd_sel_s   = bcd_data[32'(chan_sel_s) * CHW +: CHW];
  assign neg_sel_s   = neg[chan_sel_s];
  assign accept_s    = (state_r == ST_EMIT) && glyph_ready;
  assign final_s     = accept_s && (slot_r == SW'(SLOTS - 1));
  assign next_slot_s = slot_r + SW'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_EMIT;
        else       state_s = ST_IDLE;
      end
      ST_EMIT: begin
        if (final_s) state_s = ST_IDLE;
        else         state_s = ST_EMIT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Snapshot on start and registered glyph outputs, advanced one slot per acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r <= '0;
      bcd_r  <= '0;
      neg_r  <= 1'b0;
      chan_r <= '0;
      lz_r   <= 1'b0;
      addr_r <= '0;
      x0_r   <= '0;
      xs_r   <= 6'd0;
      last_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= final_s;
      if (state_r == ST_IDLE) begin
        if (start) begin
          bcd_r  <= bcd_sel_s;
          neg_r  <= neg_sel_s;
          chan_r <= chan_sel_s;
          lz_r   <= lz_blank;
          slot_r <= '0;
          addr_r <= slot_addr(SW'(0), bcd_sel_s, neg_sel_s, chan_sel_s, lz_blank);
          x0_r   <= X_W'(X_ORIGIN);
          xs_r   <= 6'(WIDE_XS);
          last_r <= 1'b0;
        end
      end else if (accept_s) begin
        if (final_s) begin
          last_r <= 1'b0;
        end else begin
          slot_r <= next_slot_s;
          addr_r <= slot_addr(next_slot_s, bcd_r, neg_r, chan_r, lz_r);
          x0_r   <= x0_r + (is_narrow(slot_r) ? X_W'(NARROW_ADV) : X_W'(WIDE_ADV));
          xs_r   <= is_narrow(next_slot_s) ? 6'(NARROW_XS) : 6'(WIDE_XS);
          last_r <= (next_slot_s == SW'(SLOTS - 1));
        end
      end
    end
  end

  assign glyph_valid = (state_r == ST_EMIT);
  assign busy        = (state_r == ST_EMIT);
  assign addr_start  = addr_r;
  assign window_x0   = x0_r;
  assign x_size      = xs_r;
  assign last        = last_r;
  assign done        = done_r;

endmodule

// File: tb/tb_lcd_field_sequencer.sv
// Randomized scoreboard bench for lcd_field_sequencer: a line-level reference model
// pushes expected glyphs on start, a negedge monitor pops them on each acceptance.
module tb_lcd_field_sequencer;

  localparam int SLOTS = 8;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] x0;
    logic [5:0]  xs;
    logic        last;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [0:0]  chan = 1'b0;
  logic        lz_blank = 1'b0;
  logic [31:0] bcd_data = 32'd0;
  logic [1:0]  neg = 2'b00;
  logic        glyph_ready = 1'b1;
  logic        glyph_valid;
  logic [8:0]  addr_start;
  logic [15:0] window_x0;
  logic [5:0]  x_size;
  logic        last;
  logic        busy;
  logic        done;

  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;
  int    acc_cnt = 0;
  logic  exp_done = 1'b0;
  item_t q[$];

  lcd_field_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chan(chan), .lz_blank(lz_blank),
    .bcd_data(bcd_data), .neg(neg), .glyph_ready(glyph_ready),
    .glyph_valid(glyph_valid), .addr_start(addr_start), .window_x0(window_x0),
    .x_size(x_size), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int dig(input int v);
    return (v > 9) ? 480 : v * 32;
  endfunction

  // Reference model: build the whole line from the display rules.
  task automatic push_line(input int c, input logic [15:0] b, input logic n, input logic lz);
    int d[4];
    int a[SLOTS];
    int first_nz;
    int x;
    item_t it;
    for (int i = 0; i < 4; i++) d[i] = int'((b >> (4 * (3 - i))) & 16'hF);
    first_nz = 3;
    for (int i = 2; i >= 0; i--) if (d[i] != 0) first_nz = i;
    a[0] = 320 + 32 * c;
    a[1] = 430;
    a[2] = n ? 448 : 480;
    for (int i = 0; i < 3; i++) a[3 + i] = (lz && i < first_nz && i < 2) ? 480 : dig(d[i]);
    a[6] = 418;
    a[7] = dig(d[3]);
    x = 20;
    for (int k = 0; k < SLOTS; k++) begin
      it.addr = a[k][8:0];
      it.x0   = x[15:0];
      it.xs   = (k == 1 || k == 6) ? 6'd12 : 6'd31;
      it.last = (k == SLOTS - 1);
      q.push_back(it);
      x += (k == 1 || k == 6) ? 30 : 40;
    end
  endtask

  task automatic start_line(input int c, input logic [15:0] b, input logic n, input logic lz);
    bcd_data = $urandom;
    neg      = 2'($urandom);
    bcd_data[c * 16 +: 16] = b;
    neg[c]   = n;
    chan     = c[0:0];
    lz_blank = lz;
    start    = 1'b1;
    push_line(c, b, n, lz);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done, scrambling inputs and poking start while busy.
  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(posedge clk); #1;
      if (done) begin
        start = 1'b0;
        break;
      end
      bcd_data = $urandom;
      neg      = 2'($urandom);
      lz_blank = 1'($urandom);
      chan     = 1'($urandom);
      start    = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      n++;
      if (n > 300) begin
        errors++;
        checks++;
        start = 1'b0;
        $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
        break;
      end
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (glyph_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || last !== 1'b0 ||
        addr_start !== 9'd0 || window_x0 !== 16'd0 || x_size !== 6'd0) begin
      errors++;
      $display("FAIL %s: got v=%b b=%b d=%b l=%b a=%0d x=%0d s=%0d, required all 0",
               name, glyph_valid, busy, done, last, addr_start, window_x0, x_size);
    end
  endtask

  // Ready driver: tied high, random, or left to the stimulus.
  initial forever begin
    @(posedge clk); #1;
    if (ready_mode == 0)      glyph_ready = 1'b1;
    else if (ready_mode == 1) glyph_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard pop on acceptance, hold stability, done pulse.
  initial begin
    item_t it;
    item_t held;
    logic  hold_v;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v   = 1'b0;
        exp_done = 1'b0;
        acc_cnt  = 0;
      end else begin
        checks++;
        if (done !== exp_done) begin
          errors++;
          $display("FAIL done_pulse: got %b, required %b", done, exp_done);
        end
        if (done && exp_done) begin
          checks++;
          if (acc_cnt != SLOTS) begin
            errors++;
            $display("FAIL accept_count: got %0d, required %0d", acc_cnt, SLOTS);
          end
          acc_cnt = 0;
        end
        exp_done = 1'b0;
        checks++;
        if (busy !== glyph_valid) begin
          errors++;
          $display("FAIL busy_valid: got busy=%b valid=%b, required equal", busy, glyph_valid);
        end
        if (hold_v && glyph_valid) begin
          checks++;
          if (addr_start !== held.addr || window_x0 !== held.x0 || x_size !== held.xs || last !== held.last) begin
            errors++;
            $display("FAIL hold_stable: got a=%0d x=%0d s=%0d l=%b, required a=%0d x=%0d s=%0d l=%b",
                     addr_start, window_x0, x_size, last, held.addr, held.x0, held.xs, held.last);
          end
        end
        hold_v = 1'b0;
        if (glyph_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_glyph: got a=%0d with empty scoreboard, required none", addr_start);
          end else if (glyph_ready) begin
            it = q.pop_front();
            checks++;
            if (addr_start !== it.addr || window_x0 !== it.x0 || x_size !== it.xs || last !== it.last) begin
              errors++;
              $display("FAIL glyph: got a=%0d x=%0d s=%0d l=%b, required a=%0d x=%0d s=%0d l=%b",
                       addr_start, window_x0, x_size, last, it.addr, it.x0, it.xs, it.last);
            end
            acc_cnt++;
            if (it.last) exp_done = 1'b1;
          end else begin
            hold_v    = 1'b1;
            held.addr = addr_start;
            held.x0   = window_x0;
            held.xs   = x_size;
            held.last = last;
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] b;
    int          c;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_values");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed lines, each started in the done cycle of the previous one.
    ready_mode = 0;
    start_line(1, 16'h0125, 1'b1, 1'b1); wait_done();
    start_line(0, 16'h0000, 1'b0, 1'b1); wait_done();
    start_line(0, 16'h0000, 1'b0, 1'b0); wait_done();
    start_line(0, 16'h1C37, 1'b0, 1'b1); wait_done();
    start_line(1, 16'h0905, 1'b1, 1'b1); wait_done();

    // Backpressure: ready low for three cycles while slot 4 is presented.
    ready_mode  = 2;
    glyph_ready = 1'b1;
    start_line(0, 16'h4567, 1'b1, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    glyph_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    glyph_ready = 1'b1;
    wait_done();
    ready_mode = 0;

    // Reset while slot 5 is presented.
    start_line(1, 16'h0087, 1'b0, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_zero("reset_midline");
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_zero("post_reset_idle");
    start_line(1, 16'h0087, 1'b0, 1'b1); wait_done();

    // Randomized lines with random backpressure.
    for (int t = 0; t < 40; t++) begin
      c = $urandom_range(0, 1);
      for (int i = 0; i < 4; i++) b[i * 4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ready_mode = $urandom_range(0, 1);
      start_line(c, b, 1'($urandom), 1'($urandom));
      wait_done();
    end

    ready_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending glyphs, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
